xor_self_test: RTL and testbench
================================

XOR_SELF_TEST -- requirements
Module: xor_self_test

Interface
REQ-001 SHALL have parameter SETTLE, default 2, the number of cycles each input pattern is held before the DUT output is sampled; legal range 1..15.
REQ-002 SHALL have parameter LOOP, default 0; when 1, a new sweep starts automatically after DONE.
REQ-003 i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  pulse or level; requests one sweep when idle.
REQ-006 i_f  input  1  output of the downstream XOR gate under test.
REQ-007 o_a  output  1  first input bit driven to the XOR gate.
REQ-008 o_b  output  1  second input bit driven to the XOR gate.
REQ-009 o_busy  output  1  high while a sweep is in progress.
REQ-010 o_done  output  1  one-cycle pulse when a sweep completes.
REQ-011 o_pass  output  1  result of the last completed sweep (1 = all four patterns correct).
REQ-012 o_fail_vec  output  4  bit k set if pattern k ({o_a,o_b}=k) mismatched in the last sweep.
REQ-013 o_err_cnt  output  3  number of mismatches in the last sweep, 0..4.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, NEXT, DONE.
REQ-015 IDLE: o_busy=0; on i_start=1, go to DRIVE with pattern index k=0 and clear the working fail vector and error count.
REQ-016 DRIVE: {o_a,o_b}=k held constant; settle counter counts SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE (1 cycle): compare i_f with expected o_a^o_b; on mismatch set working fail bit k and increment the working error count.
REQ-018 NEXT: if k=3, go to DONE; else increment k (2-bit), reload the settle counter, and go to DRIVE.
REQ-019 DONE (1 cycle): o_done=1; copy the working fail vector and count to o_fail_vec/o_err_cnt; o_pass = (count==0); go to IDLE, or to DRIVE with k=0 if LOOP=1.
REQ-020 Sweep latency SHALL be exactly 4*(SETTLE+2)+1 cycles from the first DRIVE cycle to the DONE cycle inclusive, i.e. 17 cycles for SETTLE=2.
REQ-021 o_busy SHALL be 1 in DRIVE, SAMPLE, NEXT and DONE.
REQ-022 i_start SHALL be ignored while o_busy=1; it is never queued.
REQ-023 o_a/o_b SHALL change only on the transition from NEXT to DRIVE; in IDLE they hold the last pattern (11 after a full sweep).
REQ-024 o_pass/o_fail_vec/o_err_cnt SHALL stay stable between DONE pulses; a sweep in progress does not disturb them.
REQ-025 i_f SHALL be sampled only in SAMPLE; X/glitches in other states have no effect.
REQ-026 o_err_cnt SHALL NOT wrap; the maximum is 4.

Reset
REQ-027 While i_rst_n=0, asynchronously: state=IDLE, k=0, o_a=0, o_b=0, o_busy=0, o_done=0, o_pass=0, o_fail_vec=0000, o_err_cnt=0, settle counter=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no DONE pulse; results read back as all zero.
REQ-029 After deassertion, the first possible transition is on the first rising edge with i_rst_n=1 and i_start=1.

Verification
REQ-030 Correct XOR model on i_f, SETTLE=2, i_start pulsed -> o_a/o_b step through 00,01,10,11; o_done at cycle 17; o_pass=1, o_fail_vec=0000, o_err_cnt=0.
REQ-031 i_f tied to 0 -> o_pass=0, o_fail_vec=0110, o_err_cnt=2.
REQ-032 i_f = o_a AND o_b (wrong gate) -> o_fail_vec=1110, o_err_cnt=3; i_f = NOT(a^b) -> o_fail_vec=1111, o_err_cnt=4.
REQ-033 i_start pulsed again at cycle 5 of a sweep -> ignored; exactly one o_done pulse; the next i_start after IDLE starts a fresh sweep.
REQ-034 i_rst_n driven low at cycle 9 of a sweep -> all outputs 0 immediately (asynchronous); no o_done; a restart gives the correct result.
REQ-035 LOOP=1, SETTLE=1 -> o_done pulses every 13 cycles with continuous sweeps; o_busy stays 1.

Source files
------------

// File: rtl/xor_self_test.sv
// Built-in self test for a single 2-input XOR gate: drives all four input
// patterns, samples the gate output after a settle time and reports results.
//
// state  | meaning
// IDLE   | waiting for i_start; last pattern and results held
// DRIVE  | pattern k on o_a/o_b, settle counter running down
// SAMPLE | compare i_f against a^b, record mismatch for pattern k
// NEXT   | advance to next pattern or finish the sweep
// DONE   | one-cycle completion pulse; results visible
module xor_self_test #(
  parameter int SETTLE = 2,
  parameter bit LOOP   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_vec,
  output logic [2:0] o_err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Down-counter reload: terminal count 0 ends DRIVE after SETTLE cycles.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_w_q, fail_w_d;
  logic [2:0] err_w_q, err_w_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic       pass_q, pass_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      cnt_q      <= 4'd0;
      fail_w_q   <= 4'd0;
      err_w_q    <= 3'd0;
      fail_vec_q <= 4'd0;
      err_cnt_q  <= 3'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      fail_w_q   <= fail_w_d;
      err_w_q    <= err_w_d;
      fail_vec_q <= fail_vec_d;
      err_cnt_q  <= err_cnt_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    fail_w_d   = fail_w_q;
    err_w_d    = err_w_q;
    fail_vec_d = fail_vec_q;
    err_cnt_d  = err_cnt_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = DRIVE;
          k_d      = 2'd0;
          cnt_d    = SETTLE_LD;
          fail_w_d = 4'd0;
          err_w_d  = 3'd0;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (i_f != (k_q[1] ^ k_q[0])) begin
          fail_w_d[k_q] = 1'b1;
          if (err_w_q != 3'd4) begin
            err_w_d = err_w_q + 3'd1;
          end
        end
        state_d = NEXT;
      end
      NEXT: begin
        // Results are published on entry to DONE so they are valid with o_done.
        if (k_q == 2'd3) begin
          state_d    = DONE;
          fail_vec_d = fail_w_q;
          err_cnt_d  = err_w_q;
          pass_d     = (err_w_q == 3'd0);
        end else begin
          state_d = DRIVE;
          k_d     = k_q + 2'd1;
          cnt_d   = SETTLE_LD;
        end
      end
      DONE: begin
        if (LOOP) begin
          state_d  = DRIVE;
          k_d      = 2'd0;
          cnt_d    = SETTLE_LD;
          fail_w_d = 4'd0;
          err_w_d  = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_a        = k_q[1];
  assign o_b        = k_q[0];
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_pass     = pass_q;
  assign o_fail_vec = fail_vec_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_xor_self_test.sv
// Scoreboard bench for xor_self_test: gate models on i_f, expected results
// queued at sweep launch and compared at the o_done pulse.
module tb_xor_self_test;

  localparam int S   = 2;
  localparam int LAT = 4 * (S + 2) + 1;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       pass;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       i_f;
  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_fail_vec;
  logic [2:0] o_err_cnt;

  logic       start_l;
  logic       i_f_l;
  logic       o_a_l, o_b_l, o_busy_l, o_done_l, o_pass_l;
  logic [3:0] o_fail_vec_l;
  logic [2:0] o_err_cnt_l;

  int   mode_f;
  int   errors;
  int   checks;
  res_t sb_q[$];
  res_t last_res;

  xor_self_test #(.SETTLE(S), .LOOP(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_f(i_f),
    .o_a(o_a), .o_b(o_b), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_fail_vec(o_fail_vec), .o_err_cnt(o_err_cnt)
  );

  xor_self_test #(.SETTLE(1), .LOOP(1'b1)) dut_loop (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_l), .i_f(i_f_l),
    .o_a(o_a_l), .o_b(o_b_l), .o_busy(o_busy_l), .o_done(o_done_l),
    .o_pass(o_pass_l), .o_fail_vec(o_fail_vec_l), .o_err_cnt(o_err_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: good XOR, 1: stuck at 0, 2: AND gate, 3: XNOR gate
  function automatic logic gate_model(input int mode, input logic a, input logic b);
    case (mode)
      0:       return a ^ b;
      1:       return 1'b0;
      2:       return a & b;
      default: return ~(a ^ b);
    endcase
  endfunction

  always_comb i_f = gate_model(mode_f, o_a, o_b);
  always_comb i_f_l = o_a_l ^ o_b_l;

  function automatic res_t predict(input int mode);
    res_t       r;
    logic [1:0] kk;
    r.fv = 4'd0;
    r.ec = 3'd0;
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      if (gate_model(mode, kk[1], kk[0]) != (kk[1] ^ kk[0])) begin
        r.fv[k] = 1'b1;
        r.ec    = r.ec + 3'd1;
      end
    end
    r.pass = (r.ec == 3'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Launch one sweep from a negedge; optionally pulse i_start again or pull
  // reset at a given cycle of the sweep (cycle 1 = first DRIVE cycle).
  task automatic run_sweep(input int mode, input int start_at, input int rst_at);
    int   cyc;
    bit   fin;
    bit   was_rst;
    res_t e;
    mode_f = mode;
    sb_q.push_back(predict(mode));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    fin = 1'b0;
    was_rst = 1'b0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("async_rst", {o_a, o_b, o_busy, o_done, o_pass, o_fail_vec, o_err_cnt}, 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        last_res = '{fv: 4'd0, ec: 3'd0, pass: 1'b0};
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", {o_done, o_busy}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", o_busy, 32'd0);
        fin = 1'b1;
        was_rst = 1'b1;
      end else begin
        if (cyc == start_at) start = 1'b1;
        check("busy", o_busy, 32'd1);
        if (cyc <= 4 * (S + 2)) check("pattern", {o_a, o_b}, (cyc - 1) / (S + 2));
        if (o_done) begin
          check("latency", cyc, LAT);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("fail_vec", o_fail_vec, e.fv);
            check("err_cnt", o_err_cnt, e.ec);
            check("pass", o_pass, e.pass);
            last_res = e;
          end else begin
            check("sb_empty", sb_q.size(), 32'd1);
          end
          fin = 1'b1;
        end else begin
          check("hold", {o_pass, o_fail_vec, o_err_cnt}, {last_res.pass, last_res.fv, last_res.ec});
        end
      end
    end
    check("timeout", fin, 32'd1);
    if (fin && !was_rst) begin
      repeat (3) begin
        @(negedge clk);
        start = 1'b0;
        check("post_idle", {o_busy, o_done}, 32'd0);
      end
      check("idle_pat", {o_a, o_b}, 32'd3);
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    errors   = 0;
    checks   = 0;
    mode_f   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    start_l  = 1'b0;
    last_res = '{fv: 4'd0, ec: 3'd0, pass: 1'b0};

    repeat (2) @(negedge clk);
    check("reset_outs", {o_a, o_b, o_busy, o_done, o_pass, o_fail_vec, o_err_cnt}, 32'd0);
    check("reset_loop", {o_busy_l, o_done_l}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_hold", o_busy, 32'd0);
    end

    run_sweep(0, 0, 0);
    run_sweep(1, 0, 0);
    run_sweep(2, 0, 0);
    run_sweep(3, 0, 0);
    run_sweep(0, 5, 0);
    run_sweep(1, 0, 9);
    run_sweep(0, 0, 0);
    run_sweep(3, 0, 0);

    // Free-running sweeps: SETTLE=1 gives a 13-cycle DONE period.
    start_l = 1'b1;
    @(posedge clk);
    #1 start_l = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        check("loop_busy", o_busy_l, 32'd1);
        if (o_done_l) seen = 1'b1;
      end
      check("loop_period", cyc, 32'd13);
      check("loop_pass", {o_pass_l, o_fail_vec_l, o_err_cnt_l}, 32'h80);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
